hood_mode_sequencer: RTL and testbench

HOOD_MODE_SEQUENCER -- requirements
Module: hood_mode_sequencer

---
 rtl/hood_mode_sequencer.sv | 149 ++++++++++++++
 tb/tb_hood_mode_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_mode_sequencer.sv
// Range-hood mode sequencer: power/standby/fan modes, the one-shot hurricane
// mode, delayed exit and self-clean, with a seconds countdown for timed modes.
module hood_mode_sequencer #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int HURRICANE_SEC = 60,
   parameter int EXIT_SEC      = 60,
   parameter int CLEAN_SEC     = 180
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       power_on,
   input  logic       first_mode_toggle,
   input  logic       second_mode_toggle,
   input  logic       third_mode_toggle,
   input  logic       clean_toggle,
   input  logic       menu_signal,
   output logic [2:0] current_mode,
   output logic [7:0] countdown,
   output logic       hurricane_used,
   output logic       clean_done
);

   typedef enum logic [2:0] {
      MODE_OFF    = 3'd0,
      MODE_STAND  = 3'd1,
      MODE_FIRST  = 3'd2,
      MODE_SECOND = 3'd3,
      MODE_THIRD  = 3'd4,
      MODE_EXIT   = 3'd5,
      MODE_CLEAN  = 3'd6
   } mode_t;

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

   mode_t         mode_reg, mode_next;
   logic [7:0]    cd_reg, cd_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          hurr_reg, hurr_next;
   logic          done_reg, done_next;
   logic          timed, tick, expire;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_reg  <= MODE_OFF;
         cd_reg    <= '0;
         presc_reg <= '0;
         hurr_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         mode_reg  <= mode_next;
         cd_reg    <= cd_next;
         presc_reg <= presc_next;
         hurr_reg  <= hurr_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      timed  = (mode_reg == MODE_THIRD) || (mode_reg == MODE_EXIT) || (mode_reg == MODE_CLEAN);
      tick   = timed && (presc_reg == TICK_LAST);
      // Expiry on the tick that would take the count to zero; <= guards illegal zero loads.
      expire = tick && (cd_reg <= 8'd1);

      mode_next  = mode_reg;
      cd_next    = cd_reg;
      presc_next = (timed && !tick) ? presc_reg + PW'(1) : '0;
      hurr_next  = hurr_reg;
      done_next  = 1'b0;

      if (tick && (cd_reg != 8'd0))
         cd_next = cd_reg - 8'd1;

      if (!power_on) begin
         mode_next  = MODE_OFF;
         cd_next    = '0;
         presc_next = '0;
         hurr_next  = 1'b0;
      end else begin
         case (mode_reg)
            MODE_OFF: begin
               mode_next = MODE_STAND;
               cd_next   = '0;
            end
            MODE_STAND: begin
               if (third_mode_toggle && !hurr_reg) begin
                  mode_next  = MODE_THIRD;
                  cd_next    = 8'(HURRICANE_SEC);
                  presc_next = '0;
                  hurr_next  = 1'b1;
               end else if (second_mode_toggle) begin
                  mode_next = MODE_SECOND;
               end else if (first_mode_toggle) begin
                  mode_next = MODE_FIRST;
               end else if (clean_toggle) begin
                  mode_next  = MODE_CLEAN;
                  cd_next    = 8'(CLEAN_SEC);
                  presc_next = '0;
               end
            end
            MODE_FIRST: begin
               if (menu_signal)             mode_next = MODE_STAND;
               else if (second_mode_toggle) mode_next = MODE_SECOND;
            end
            MODE_SECOND: begin
               if (menu_signal)            mode_next = MODE_STAND;
               else if (first_mode_toggle) mode_next = MODE_FIRST;
            end
            MODE_THIRD: begin
               if (menu_signal) begin
                  mode_next  = MODE_EXIT;
                  cd_next    = 8'(EXIT_SEC);
                  presc_next = '0;
               end else if (expire) begin
                  mode_next  = MODE_SECOND;
                  cd_next    = '0;
                  presc_next = '0;
               end
            end
            MODE_EXIT: begin
               if (expire) begin
                  mode_next  = MODE_STAND;
                  cd_next    = '0;
                  presc_next = '0;
               end
            end
            MODE_CLEAN: begin
               if (expire) begin
                  mode_next  = MODE_STAND;
                  cd_next    = '0;
                  presc_next = '0;
                  done_next  = 1'b1;
               end
            end
            default: begin
               mode_next  = MODE_STAND;
               cd_next    = '0;
               presc_next = '0;
            end
         endcase
      end
   end

   assign current_mode   = mode_reg;
   assign countdown      = cd_reg;
   assign hurricane_used = hurr_reg;
   assign clean_done     = done_reg;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Directed bench for hood_mode_sequencer: a cycle-budget model checked every
// cycle, plus hand-computed literal checks at key points of each scenario.
module tb_hood_mode_sequencer;

   localparam int T = 4;
   localparam int H = 3;
   localparam int E = 2;
   localparam int C = 2;

   localparam logic [4:0] THR  = 5'b10000;
   localparam logic [4:0] SEC  = 5'b01000;
   localparam logic [4:0] FST  = 5'b00100;
   localparam logic [4:0] CLN  = 5'b00010;
   localparam logic [4:0] MNU  = 5'b00001;
   localparam logic [4:0] NONE = 5'b00000;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       power_on = 1'b0;
   logic [4:0] tog = '0;
   logic [2:0] current_mode;
   logic [7:0] countdown;
   logic       hurricane_used;
   logic       clean_done;

   int vectors = 0;
   int miscompares = 0;

   hood_mode_sequencer #(
      .TICKS_PER_SEC(T),
      .HURRICANE_SEC(H),
      .EXIT_SEC     (E),
      .CLEAN_SEC    (C)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .power_on          (power_on),
      .first_mode_toggle (tog[2]),
      .second_mode_toggle(tog[3]),
      .third_mode_toggle (tog[4]),
      .clean_toggle      (tog[1]),
      .menu_signal       (tog[0]),
      .current_mode      (current_mode),
      .countdown         (countdown),
      .hurricane_used    (hurricane_used),
      .clean_done        (clean_done)
   );

   always #5 clk = ~clk;

   // Model: a timed mode is a budget of clock cycles; the displayed seconds
   // are the remaining budget rounded up to whole seconds.
   int   m_mode;
   int   m_left;
   logic m_hurr;
   logic m_done;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_mode <= 0;
         m_left <= 0;
         m_hurr <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (!power_on) begin
            m_mode <= 0;
            m_left <= 0;
            m_hurr <= 1'b0;
         end else begin
            case (m_mode)
               0: m_mode <= 1;
               1: begin
                  if (tog[4] && !m_hurr) begin
                     m_mode <= 4;
                     m_left <= H * T;
                     m_hurr <= 1'b1;
                  end else if (tog[3]) m_mode <= 3;
                  else if (tog[2]) m_mode <= 2;
                  else if (tog[1]) begin
                     m_mode <= 6;
                     m_left <= C * T;
                  end
               end
               2: if (tog[0]) m_mode <= 1; else if (tog[3]) m_mode <= 3;
               3: if (tog[0]) m_mode <= 1; else if (tog[2]) m_mode <= 2;
               4: begin
                  if (tog[0]) begin
                     m_mode <= 5;
                     m_left <= E * T;
                  end else if (m_left == 1) begin
                     m_mode <= 3;
                     m_left <= 0;
                  end else m_left <= m_left - 1;
               end
               5: begin
                  if (m_left == 1) begin
                     m_mode <= 1;
                     m_left <= 0;
                  end else m_left <= m_left - 1;
               end
               6: begin
                  if (m_left == 1) begin
                     m_mode <= 1;
                     m_left <= 0;
                     m_done <= 1'b1;
                  end else m_left <= m_left - 1;
               end
               default: m_mode <= 1;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         vectors++;
         if (current_mode !== 3'(m_mode) || countdown !== 8'((m_left + T - 1) / T) ||
             hurricane_used !== m_hurr || clean_done !== m_done) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got mode=%0d cd=%0d hurr=%0b done=%0b, required mode=%0d cd=%0d hurr=%0b done=%0b",
                     $time, current_mode, countdown, hurricane_used, clean_done,
                     m_mode, (m_left + T - 1) / T, m_hurr, m_done);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic pw, input logic [4:0] t);
      power_on = pw;
      tog = t;
      $display("t=%0t drive power_on=%0b third/second/first/clean/menu=%05b", $time, pw, t);
      @(negedge clk);
      tog = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      power_on = 1'b1;
      @(negedge clk);
      #1;
      check("reset_mode", 8'(current_mode), 8'd0);
      check("reset_cd", countdown, 8'd0);
      check("reset_hurr", 8'(hurricane_used), 8'd0);
      check("reset_done", 8'(clean_done), 8'd0);
      @(negedge clk);
      #2 rstn = 1'b1;
      check("release_off", 8'(current_mode), 8'd0);
      @(negedge clk);
      check("release_stand", 8'(current_mode), 8'd1);
      check("release_cd", countdown, 8'd0);

      // hurricane runs to completion, then is refused in the same session
      drive(1'b1, THR);
      check("third_enter", 8'(current_mode), 8'd4);
      check("third_cd3", countdown, 8'd3);
      check("third_hurr", 8'(hurricane_used), 8'd1);
      idle(3);
      check("third_cd3_hold", countdown, 8'd3);
      idle(1);
      check("third_cd2", countdown, 8'd2);
      idle(7);
      check("third_last", 8'(current_mode), 8'd4);
      check("third_cd1", countdown, 8'd1);
      idle(1);
      check("third_to_second", 8'(current_mode), 8'd3);
      check("second_cd0", countdown, 8'd0);
      drive(1'b1, MNU);
      check("second_menu", 8'(current_mode), 8'd1);
      drive(1'b1, THR);
      check("third_refused", 8'(current_mode), 8'd1);
      drive(1'b1, THR | SEC);
      check("third_refused_second", 8'(current_mode), 8'd3);
      drive(1'b1, MNU);

      // power cycle clears hurricane_used; toggles ignored while off
      drive(1'b0, THR);
      check("off_mode", 8'(current_mode), 8'd0);
      check("off_hurr", 8'(hurricane_used), 8'd0);
      drive(1'b1, NONE);
      check("repower_stand", 8'(current_mode), 8'd1);
      drive(1'b1, THR | SEC | FST | CLN);
      check("third_priority", 8'(current_mode), 8'd4);
      idle(4);
      check("third_cd2_again", countdown, 8'd2);
      drive(1'b1, MNU);
      check("exit_enter", 8'(current_mode), 8'd5);
      check("exit_cd", countdown, 8'd2);
      drive(1'b1, THR | SEC | FST | CLN | MNU);
      check("exit_ignores", 8'(current_mode), 8'd5);
      idle(6);
      check("exit_last", 8'(current_mode), 8'd5);
      check("exit_cd1", countdown, 8'd1);
      idle(1);
      check("exit_to_stand", 8'(current_mode), 8'd1);

      // fan mode priorities and menu precedence
      drive(1'b1, FST | SEC | CLN);
      check("stand_second_wins", 8'(current_mode), 8'd3);
      drive(1'b1, FST);
      check("second_to_first", 8'(current_mode), 8'd2);
      drive(1'b1, MNU | SEC);
      check("first_menu_wins", 8'(current_mode), 8'd1);
      drive(1'b1, SEC);
      drive(1'b1, MNU | FST);
      check("second_menu_wins", 8'(current_mode), 8'd1);

      // self-clean to completion, then aborted by power loss
      drive(1'b1, CLN);
      check("clean_enter", 8'(current_mode), 8'd6);
      check("clean_cd", countdown, 8'd2);
      drive(1'b1, THR | MNU);
      check("clean_ignores", 8'(current_mode), 8'd6);
      idle(6);
      check("clean_last", 8'(current_mode), 8'd6);
      check("clean_no_done_yet", 8'(clean_done), 8'd0);
      idle(1);
      check("clean_to_stand", 8'(current_mode), 8'd1);
      check("clean_done_pulse", 8'(clean_done), 8'd1);
      idle(1);
      check("clean_done_drop", 8'(clean_done), 8'd0);
      drive(1'b1, CLN);
      idle(3);
      drive(1'b0, NONE);
      check("clean_abort_off", 8'(current_mode), 8'd0);
      check("clean_abort_cd", countdown, 8'd0);
      check("clean_abort_done", 8'(clean_done), 8'd0);
      drive(1'b1, NONE);
      idle(8);
      check("clean_abort_stand", 8'(current_mode), 8'd1);

      // reset in the middle of a countdown abandons the timed mode
      drive(1'b1, CLN);
      idle(2);
      #2 rstn = 1'b0;
      #1;
      check("midreset_mode", 8'(current_mode), 8'd0);
      check("midreset_cd", countdown, 8'd0);
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      check("midreset_stand", 8'(current_mode), 8'd1);
      idle(10);
      check("midreset_no_done", 8'(clean_done), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
